// File: rtl/seq_tx1001_if.sv
// Parallel-in / serial-out handshake bundle between a frame requester and the
// 1001-sync frame transmitter.
interface seq_tx1001_if #(
    parameter int DATA_W = 8
);
    logic              start;
    logic [DATA_W-1:0] data;
    logic              x;
    logic              busy;
    logic              done;

    modport master (
        output start,
        output data,
        input  x,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  data,
        output x,
        output busy,
        output done
    );
endinterface

// File: rtl/seq_tx1001.sv
// Serial frame transmitter: sync 1,0,0,1, payload MSB first, optional even parity.
// All outputs are registered; x_q always holds the bit for the cycle after the edge.
module seq_tx1001 #(
    parameter int DATA_W    = 8,
    parameter bit PARITY_EN = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    seq_tx1001_if.slave  bus
);
    localparam int CNT_W = $clog2((DATA_W > 4) ? DATA_W : 4);
    localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(3);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        DATA = 2'd2,
        PAR  = 2'd3
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] shreg_q;
    logic              par_q;
    logic              x_q;
    logic              busy_q;
    logic              done_q;

    // Each branch loads the state/index that holds during the next cycle and
    // the bit that goes with it, so x_q never depends on inputs combinationally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            par_q   <= 1'b0;
            x_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    x_q    <= 1'b0;
                    busy_q <= 1'b0;
                    if (bus.start) begin
                        state_q <= SYNC;
                        cnt_q   <= '0;
                        shreg_q <= bus.data;
                        par_q   <= ^bus.data;
                        x_q     <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                SYNC: begin
                    if (cnt_q == SYNC_LAST) begin
                        state_q <= DATA;
                        cnt_q   <= '0;
                        x_q     <= shreg_q[DATA_W-1];
                        shreg_q <= shreg_q << 1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        // Sync pattern 1,0,0,1: only index 3 is high after index 0.
                        x_q   <= (cnt_q == CNT_W'(2));
                    end
                end
                DATA: begin
                    if (cnt_q == DATA_LAST) begin
                        if (PARITY_EN) begin
                            state_q <= PAR;
                            x_q     <= par_q;
                        end else begin
                            state_q <= IDLE;
                            cnt_q   <= '0;
                            x_q     <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        cnt_q   <= cnt_q + CNT_W'(1);
                        x_q     <= shreg_q[DATA_W-1];
                        shreg_q <= shreg_q << 1;
                    end
                end
                PAR: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    x_q     <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    x_q     <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.x    = x_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_seq_tx1001.sv
// Randomised scoreboard bench for seq_tx1001 (8-bit + parity), plus a directed
// check of a 4-bit no-parity instance.
module tb_seq_tx1001;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    seq_tx1001_if #(.DATA_W(8)) if1 ();
    seq_tx1001_if #(.DATA_W(4)) if2 ();

    seq_tx1001 #(.DATA_W(8), .PARITY_EN(1'b1)) dut1 (.clk(clk), .reset(reset), .bus(if1));
    seq_tx1001 #(.DATA_W(4), .PARITY_EN(1'b0)) dut2 (.clk(clk), .reset(reset), .bus(if2));

    typedef struct {
        logic b;
        int   cyc;
    } ent_t;

    ent_t exp_q[$];
    int   done_stamp_q[$];
    int   checks = 0;
    int   fails  = 0;
    int   cyc    = 0;
    int   rem    = 0;
    int   exp_done_cnt = 0;
    int   seen_done_cnt = 0;

    localparam int L = 4 + 8 + 1;

    // Reference model: a frame is the sync nibble, the payload MSB first and the
    // count of ones mod 2, stamped with the cycle each bit must appear in.
    task automatic push_frame(input logic [7:0] d);
        int ones = 0;
        int c = cyc;
        logic [3:0] sync = 4'b1001;
        for (int i = 0; i < 4; i++) exp_q.push_back('{sync[3-i], c + i});
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back('{d[7-i], c + 4 + i});
            if (d[7-i]) ones++;
        end
        exp_q.push_back('{logic'(ones % 2), c + 12});
        done_stamp_q.push_back(c + L);
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            exp_q.delete();
            done_stamp_q.delete();
            rem = 0;
        end else begin
            cyc++;
            if (rem > 0) begin
                rem--;
                if (rem == 0) exp_done_cnt++;
            end else if (if1.start) begin
                push_frame(if1.data);
                rem = L;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents a frame bit or done.
    always @(negedge clk) begin
        ent_t e;
        if (!reset) begin
            checks++;
            if ({if1.x, if1.busy, if1.done} != 3'b000) begin
                fails++;
                $display("FAIL reset_outputs: x/busy/done=%b required 000", {if1.x, if1.busy, if1.done});
            end
        end else begin
            if (if1.busy) begin
                checks++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL busy_unexpected: cyc=%0d busy=1 required 0", cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || if1.x !== e.b) begin
                        fails++;
                        $display("FAIL x_bit: cyc=%0d x=%b required %b (expected at cyc %0d)", cyc, if1.x, e.b, e.cyc);
                    end
                end
            end else begin
                checks++;
                if (if1.x !== 1'b0 || (exp_q.size() != 0 && exp_q[0].cyc <= cyc)) begin
                    fails++;
                    $display("FAIL idle_line: cyc=%0d x=%b busy=0 required x=0 busy=%0d", cyc, if1.x,
                             (exp_q.size() != 0 && exp_q[0].cyc <= cyc));
                    if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) void'(exp_q.pop_front());
                end
            end
            if (if1.done) begin
                seen_done_cnt++;
                checks++;
                if (done_stamp_q.size() == 0) begin
                    fails++;
                    $display("FAIL done_unexpected: cyc=%0d done=1 required 0", cyc);
                end else if (done_stamp_q[0] != cyc) begin
                    fails++;
                    $display("FAIL done_time: done at cyc %0d required cyc %0d", cyc, done_stamp_q[0]);
                    void'(done_stamp_q.pop_front());
                end else begin
                    void'(done_stamp_q.pop_front());
                end
            end else if (done_stamp_q.size() != 0 && done_stamp_q[0] <= cyc) begin
                checks++;
                fails++;
                $display("FAIL done_missing: cyc=%0d done=0 required 1", cyc);
                void'(done_stamp_q.pop_front());
            end
        end
    end

    task automatic send1(input logic [7:0] d);
        @(negedge clk);
        if1.start = 1'b1;
        if1.data  = d;
        @(negedge clk);
        if1.start = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp2;
        if1.start = 1'b0;
        if1.data  = '0;
        if2.start = 1'b0;
        if2.data  = '0;
        idle_cycles(3);
        #2 reset = 1'b1;

        // 4-bit, no parity: 1,0,0,1 then 1,0,0,1, done at k+8.
        exp2 = 8'b1001_1001;
        @(negedge clk);
        if2.start = 1'b1;
        if2.data  = 4'h9;
        @(negedge clk);
        if2.start = 1'b0;
        if2.data  = 4'h6;
        for (int j = 0; j < 10; j++) begin
            logic [2:0] got, want;
            got  = {if2.x, if2.busy, if2.done};
            want = (j < 8) ? {exp2[7-j], 2'b10} : (j == 8) ? 3'b001 : 3'b000;
            checks++;
            if (got !== want) begin
                fails++;
                $display("FAIL w4_frame[%0d]: x/busy/done=%b required %b", j, got, want);
            end
            @(negedge clk);
        end

        // Basic frames, including odd-weight payload.
        send1(8'hA5);
        idle_cycles(16);
        send1(8'h01);
        idle_cycles(16);

        // Requests during a frame are ignored.
        send1(8'hA5);
        if1.data = 8'h00;
        idle_cycles(3);
        @(negedge clk);
        if1.start = 1'b1;
        if1.data  = 8'hFF;
        @(negedge clk);
        if1.start = 1'b0;
        idle_cycles(20);

        // Reset during payload bit 2 clears outputs at once.
        send1(8'hA5);
        idle_cycles(5);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({if1.x, if1.busy, if1.done} !== 3'b000) begin
            fails++;
            $display("FAIL async_reset: x/busy/done=%b required 000", {if1.x, if1.busy, if1.done});
        end
        @(negedge clk);
        #2 reset = 1'b1;
        idle_cycles(2);
        send1(8'hFF);
        idle_cycles(16);

        // Continuous start: 14-cycle period.
        @(negedge clk);
        if1.start = 1'b1;
        if1.data  = 8'h3C;
        idle_cycles(45);
        if1.start = 1'b0;
        idle_cycles(16);

        // Random traffic with data churning every cycle.
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if1.start = ($urandom_range(0, 3) == 0);
            if1.data  = 8'($urandom);
        end
        if1.start = 1'b0;
        idle_cycles(20);

        checks++;
        if (exp_q.size() != 0 || done_stamp_q.size() != 0) begin
            fails++;
            $display("FAIL leftovers: bits=%0d dones=%0d required 0 0", exp_q.size(), done_stamp_q.size());
        end
        checks++;
        if (seen_done_cnt != exp_done_cnt) begin
            fails++;
            $display("FAIL done_count: saw %0d required %0d", seen_done_cnt, exp_done_cnt);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
